// File: rtl/dsp_cfg_pkg.sv
// Shared types and CRC helpers for the DSP configuration-chain loader.
// The CRC constants are only used when DSP_CFG_CRC_EN is defined.
package dsp_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // One serial step of CRC-16-CCITT, MSB-first register, one data bit in.
  function automatic logic [15:0] crc16_bit(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/dsp_cfg_serializer.sv
// Word-to-bit serializer: holds one word, shifts it LSB first and drives
// the registered serial pins of the configuration chain.
module dsp_cfg_serializer #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              active,
  input  logic              last_bit,
  input  logic [WORD_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              shifting,
  output logic              ser_out,
  output logic              ser_en
);

  localparam int WREM_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] sh_reg;
  logic [WREM_W-1:0] wrem;
  logic              xfer;

  assign shifting = active && (wrem != '0);
  // Take the next word while the last bit of the current one shifts out,
  // unless that bit also completes the chain.
  assign ready    = active && ((wrem == '0) || ((wrem == WREM_W'(1)) && !last_bit));
  assign xfer     = valid && ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_reg  <= '0;
      wrem    <= '0;
      ser_out <= 1'b0;
      ser_en  <= 1'b0;
    end else if (clr) begin
      wrem   <= '0;
      ser_en <= 1'b0;
    end else begin
      ser_en <= shifting;
      if (shifting) ser_out <= sh_reg[0];
      if (xfer) begin
        sh_reg <= data;
        wrem   <= WREM_W'(WORD_W);
      end else if (last_bit) begin
        wrem <= '0;
      end else if (shifting) begin
        sh_reg <= sh_reg >> 1;
        wrem   <= wrem - WREM_W'(1);
      end
    end
  end

endmodule

// File: rtl/dsp_config_loader.sv
// Serial configuration writer for the DSP daisy-chain: FSM, chain bit count
// and, when DSP_CFG_CRC_EN is defined, a trailing CRC-16 check word.
module dsp_config_loader
  import dsp_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              configuration_input,
  output logic              configuration_enable,
  output logic              busy,
  output logic              done,
`ifdef DSP_CFG_CRC_EN
  output logic              crc_err,
`endif
  output state_t            dbg_state
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic             chain_full;
  logic             ser_active;
  logic             shifting;
  logic             last_bit;
  logic             ser_ready;
  logic             clr;
  logic             load_end;

  assign chain_full = (bit_cnt == CNT_W'(CHAIN_LEN));
  assign ser_active = (state == LOAD) && !chain_full;
  assign last_bit   = shifting && (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign clr        = abort || ((state == IDLE) && start);
  assign dbg_state  = state;

  // Handshake: a word moves when cfg_valid && cfg_ready at a rising edge;
  // the source holds cfg_data stable while cfg_valid is high and unaccepted.
  dsp_cfg_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (clr),
    .active   (ser_active),
    .last_bit (last_bit),
    .data     (cfg_data),
    .valid    (cfg_valid),
    .ready    (ser_ready),
    .shifting (shifting),
    .ser_out  (configuration_input),
    .ser_en   (configuration_enable)
  );

`ifdef DSP_CFG_CRC_EN
  logic [15:0] crc;
  logic [15:0] crc_final;
  logic        crc_ready;
  logic        crc_xfer;

  // The last chain bit may still be on the pins when the CRC word arrives.
  assign crc_final = configuration_enable ? crc16_bit(crc, configuration_input) : crc;
  assign crc_ready = (state == LOAD) && chain_full;
  assign crc_xfer  = cfg_valid && crc_ready;
  assign cfg_ready = ser_ready || crc_ready;
  assign load_end  = crc_xfer;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crc     <= CRC_INIT;
      crc_err <= 1'b0;
    end else if (!abort) begin
      if ((state == IDLE) && start) begin
        crc     <= CRC_INIT;
        crc_err <= 1'b0;
      end else if (configuration_enable) begin
        crc <= crc16_bit(crc, configuration_input);
      end
      if (crc_xfer) crc_err <= (cfg_data[15:0] != crc_final);
    end
  end
`else
  assign cfg_ready = ser_ready;
  assign load_end  = chain_full;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        bit_cnt <= '0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state   <= LOAD;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
          LOAD: begin
            if (shifting) bit_cnt <= bit_cnt + CNT_W'(1);
            if (load_end) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dsp_config_loader.sv
// Bench for dsp_config_loader (CHAIN_LEN=40, WORD_W=16); the CRC scenarios
// are included when DSP_CFG_CRC_EN is defined.
module tb_dsp_config_loader;
  import dsp_cfg_pkg::*;

  localparam int CHAIN = 40;
  localparam int WW    = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [WW-1:0] cfg_data = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic          configuration_input;
  logic          configuration_enable;
  logic          busy;
  logic          done;
  state_t        dbg_state;
`ifdef DSP_CFG_CRC_EN
  logic          crc_err;
  logic [15:0]   crc_model;
  logic [15:0]   crc_xor = 16'h0000;
`endif

  dsp_config_loader #(.CHAIN_LEN(CHAIN), .WORD_W(WW)) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .start                (start),
    .abort                (abort),
    .cfg_data             (cfg_data),
    .cfg_valid            (cfg_valid),
    .cfg_ready            (cfg_ready),
    .configuration_input  (configuration_input),
    .configuration_enable (configuration_enable),
    .busy                 (busy),
    .done                 (done),
`ifdef DSP_CFG_CRC_EN
    .crc_err              (crc_err),
`endif
    .dbg_state            (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [0:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int pushed, bits_seen, gap_cnt, cur_run, max_run, done_cnt;
  logic last_bit, prev_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

`ifdef DSP_CFG_CRC_EN
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction
`endif

  task automatic clear_sb();
    exp_q.delete();
    pushed = 0; bits_seen = 0; gap_cnt = 0; cur_run = 0; max_run = 0; done_cnt = 0;
    prev_en = 1'b0; last_bit = 1'b0;
`ifdef DSP_CFG_CRC_EN
    crc_model = 16'hFFFF;
`endif
  endtask

  // monitor: pops one expected bit per enabled cycle
  always @(negedge clk) begin
    if (rstn) begin
      if (configuration_enable) begin
        if (exp_q.size() == 0) check("extra_bit", 1, 0);
        else check($sformatf("bit%0d", bits_seen), configuration_input, exp_q.pop_front());
        bits_seen++;
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
        last_bit = configuration_input;
      end else begin
        cur_run = 0;
        if (busy && bits_seen > 0 && bits_seen < CHAIN) begin
          gap_cnt++;
          check("held_input", configuration_input, last_bit);
        end
      end
      if (done) begin
        done_cnt++;
        check("en_in_done", configuration_enable, 0);
`ifndef DSP_CFG_CRC_EN
        check("done_after_last", {31'd0, prev_en}, 1);
`endif
      end
      prev_en = configuration_enable;
    end
  end

  // driver tasks
  task automatic send_word(input logic [WW-1:0] w);
    bit ok = 0;
    cfg_data  = w;
    cfg_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (cfg_ready) begin
        ok = 1;
        for (int i = 0; i < WW; i++) begin
          if (pushed < CHAIN) begin
            exp_q.push_back(w[i]);
`ifdef DSP_CFG_CRC_EN
            crc_model = crc_step(crc_model, w[i]);
`endif
            pushed++;
          end
        end
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic stall_ready(input int k);
    int seen = 0;
    for (int n = 0; n < 200 && seen < k; n++) begin
      #1;
      if (cfg_ready) seen++;
      @(negedge clk);
    end
    check("stall_ready_seen", seen, k);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input bit probe);
    int rdy_hi = 0;
    if (probe) begin
      cfg_data  = 16'hBEEF;
      cfg_valid = 1'b1;
    end
    for (int n = 0; n < 300; n++) begin
      #1;
      if (probe && cfg_ready) rdy_hi++;
      if (done_cnt != 0) break;
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    @(negedge clk);
    #1;
    check("done_once", done_cnt, 1);
    if (probe) check("no_4th_xfer", rdy_hi, 0);
    check("bits_total", bits_seen, CHAIN);
    check("exp_q_empty", exp_q.size(), 0);
    check("idle_after_done", 32'(dbg_state), 32'(IDLE));
  endtask

  task automatic load_chain(input bit stall, input bit ign_start);
    clear_sb();
    pulse_start();
    send_word(16'hA5A5);
    if (stall) stall_ready(5);
    if (ign_start) begin
      check("busy_at_restart", busy, 1);
      pulse_start();
    end
    send_word(16'h0F0F);
    send_word(16'h00FF);
`ifdef DSP_CFG_CRC_EN
    send_word(crc_model ^ crc_xor);
    wait_done(0);
    check("crc_err", crc_err, (crc_xor != 16'h0000));
`else
    wait_done(1);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_sb();
    repeat (3) @(negedge clk);
    check("rst_enable", configuration_enable, 0);
    check("rst_input", configuration_input, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", cfg_ready, 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // continuous load
    load_chain(0, 0);
    check("cont_gap", gap_cnt, 0);
    check("cont_run", max_run, CHAIN);

    // stalled source between words 1 and 2
    load_chain(1, 0);
    check("stall_gap", gap_cnt, 5);
    check("stall_run", max_run, CHAIN - WW);

    // abort the cycle after the 20th bit, then a fresh full load
    clear_sb();
    pulse_start();
    send_word(16'hA5A5);
    send_word(16'h0F0F);
    for (int n = 0; n < 200 && bits_seen < 20; n++) begin
      @(negedge clk);
      #1;
    end
    check("reach_bit20", bits_seen, 20);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    check("abort_enable", configuration_enable, 0);
    check("abort_busy", busy, 0);
    check("abort_bits", bits_seen, 21);
    repeat (5) @(negedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    check("abort_no_more_bits", bits_seen, 21);
    check("abort_ready", cfg_ready, 0);
    load_chain(0, 0);
    check("reload_run", max_run, CHAIN);

    // start while busy is ignored
    load_chain(0, 1);
    check("ign_gap", gap_cnt, 0);
    check("ign_run", max_run, CHAIN);

`ifdef DSP_CFG_CRC_EN
    // corrupted CRC word
    crc_xor = 16'h0008;
    load_chain(0, 0);
    crc_xor = 16'h0000;
    load_chain(0, 0);
`endif

    // asynchronous reset mid-word
    clear_sb();
    pulse_start();
    send_word(16'hA5A5);
    for (int n = 0; n < 50 && bits_seen < 1; n++) begin
      @(negedge clk);
      #1;
    end
    check("pre_rst_input", configuration_input, 1);
    #1;
    rstn = 1'b0;
    #1;
    check("arst_enable", configuration_enable, 0);
    check("arst_input", configuration_input, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_ready", cfg_ready, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_state", 32'(dbg_state), 32'(IDLE));
    check("post_rst_ready", cfg_ready, 0);
    check("post_rst_enable", configuration_enable, 0);
    clear_sb();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dsp_config_loader.md
Name: dsp_config_loader

Overview:
- Serial configuration writer for the DSP block's configuration chain.
- Accepts parallel configuration words over a valid/ready stream and shifts exactly CHAIN_LEN bits, LSB first, onto `configuration_input`, qualified by `configuration_enable`.
- Sits between the configuration controller or host FIFO and the first DSP's `configuration_input`/`configuration_enable` pins; the DSP registers those pins, so this block drives them from flops.

Parameters:
- CHAIN_LEN, 1024: total configuration bits in the daisy-chain (all DSPs in series); must be ≥1.
- WORD_W, 32: width of one input configuration word; must be ≥2.
- CNT_W, $clog2(CHAIN_LEN+1): width of the bit counter (derived localparam).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a chain load; honoured only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- cfg_data  in  WORD_W  configuration word; bit 0 is shifted first.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  loader accepts cfg_data this cycle (transfer = valid & ready).
- configuration_input  out  1  serial config bit to the chain (registered).
- configuration_enable  out  1  shift strobe to the chain; high exactly on cycles carrying a valid bit (registered).
- busy  out  1  high in LOAD.
- done  out  1  one-cycle pulse when CHAIN_LEN bits have been shifted.

Behaviour:
- Reset (rstn low, async): state=IDLE, all outputs 0, shift register, word bit count and chain bit count cleared.
- States:
  - IDLE: start moves to LOAD and clears bit_cnt.
  - LOAD: on bit_cnt==CHAIN_LEN, move to DONE.
  - DONE: lasts one cycle, done=1, then IDLE.
- Shift register: sh_reg[WORD_W-1:0] with word bits-remaining counter wrem.
- cfg_ready = (state==LOAD) && (bit_cnt < CHAIN_LEN) && (wrem==0 || (wrem==1 && shifting)). This gives gapless back-to-back words.
- On transfer: sh_reg<=cfg_data and wrem<=WORD_W. Behaviour is the same when the transfer coincides with the last bit of the previous word.
- Shifting condition: state==LOAD && wrem!=0 && bit_cnt<CHAIN_LEN. When shifting, on the next clock:
  - configuration_input<=sh_reg[0], configuration_enable<=1;
  - sh_reg>>=1, wrem--, bit_cnt++.
- When not shifting, configuration_enable<=0 and configuration_input holds its value. The stall is invisible to the chain.
- Latency: a word accepted at edge t has its bit 0 on the output after edge t+1. With continuous cfg_valid, configuration_enable stays high for CHAIN_LEN consecutive cycles.
- Final word: if CHAIN_LEN is not a multiple of WORD_W, the upper bits of the last word are discarded.
  - On bit_cnt reaching CHAIN_LEN: wrem<=0, cfg_ready=0.
  - No further words are accepted until the next start.
- Transition to DONE follows the cycle that shifts the last bit. configuration_enable is 0 in DONE.
- start in LOAD or DONE is ignored (no restart, no error).
- abort has priority over all other events in the same cycle:
  - next state IDLE; configuration_enable<=0; wrem, bit_cnt cleared; done not pulsed;
  - chain contents are undefined and a fresh start is required.
- Reset mid-LOAD behaves like abort, but asynchronously.
- cfg_valid while not ready: the word is held by the source (standard valid/ready; data must stay stable).

Optional Feature:
- Macro: DSP_CFG_CRC_EN.
- Defined:
  - a CRC-16-CCITT (poly 0x1021, init 0xFFFF) is computed over every bit driven with configuration_enable=1;
  - after CHAIN_LEN bits, LOAD accepts one further word whose low 16 bits are the expected CRC, then enters DONE;
  - extra output crc_err (1 bit) is set in DONE on mismatch and held until next start or reset.
- Undefined: no CRC word is consumed, no crc_err port exists, and timing is exactly as described above.

Decomposition:
- Package dsp_cfg_pkg:
  - state enum (IDLE, LOAD, DONE);
  - CRC polynomial and init constants;
  - function crc16_bit(crc, bit).
- One natural sub-module, dsp_cfg_serializer: sh_reg, wrem, the ready term and registered serial outputs. The top holds the FSM, bit_cnt and the optional CRC.

Test Plan:
- Test parameters: CHAIN_LEN=40, WORD_W=16.
- Continuous load: start, then words 0xA5A5, 0x0F0F, 0x00FF always valid.
  - configuration_enable high for 40 consecutive cycles, bits 0xA5A5 LSB-first, then 0x0F0F, then 0xFF low byte.
  - cfg_ready drops after 3 transfers; done pulses once the cycle after the 40th bit.
- Stalled source: cfg_valid low for 5 cycles between words 1 and 2.
  - enable low for exactly 5 cycles with configuration_input held.
  - 40 total enabled bits, sequence identical to the continuous load.
- Abort at bit 20: asserting abort the cycle after the 20th enabled bit.
  - next cycle IDLE, enable 0, no done.
  - A new start then shifts a full 40 bits.
- Ignored start: start pulsed while busy=1.
  - no change in bit_cnt or output sequence.
- Async reset: rstn low mid-word.
  - outputs 0 immediately (before next edge).
  - After release, state is IDLE and cfg_ready=0.
- With DSP_CFG_CRC_EN: load 40 bits plus a correct CRC word gives crc_err=0; a CRC word with bit 3 flipped gives crc_err=1 in DONE.
